spi_ram_responder: RTL and testbench

- SPI Mode-0 responder modelling the byte-wide serial RAM that the SPI CPU wrapper talks to as master; lets the CPU run in silicon/FPGA loopback without an external RAM chip.
- Oversamples the SPI pins in the system clock domain, decodes READ/WRITE commands with an 8-bit address, and serves an internal register-file memory with address auto-increment.
- Drives MISO back to the master. A side debug port exposes memory contents to the bench.

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_in_sync.sv | 68 ++++++
 rtl/spi_ram_responder.sv | 200 ++++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// ---------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI RAM responder: the two opcodes the
// responder understands and the state encoding of its byte-level FSM.
// ---------------------------------------------------------------------------
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RADDR,
        WADDR,
        READ,
        WRITE,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// ---------------------------------------------------------------------------
// spi_in_sync
// Brings the asynchronous SPI pins into the clk domain and detects the SCK
// edges there.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   spi_cs_n        raw chip select (active low)
//   spi_sck         raw SPI clock (CPOL=0)
//   spi_mosi        raw master data
//   cs_n_s          synchronized chip select
//   mosi_s          synchronized master data
//   sck_rise        one-clk pulse on a synchronized SCK rising edge
//   sck_fall        one-clk pulse on a synchronized SCK falling edge
// ---------------------------------------------------------------------------
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   sck_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Shift each pin one stage further down its chain; the extra SCK flop
    // holds the previous synchronized value for edge detection.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_dly_d   = sck_s;
    end

    // Chip select resets to the deselected level so the responder comes out
    // of reset idle rather than seeing a spurious select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_dly_q   <= sck_dly_d;
        end
    end

    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;

endmodule

// File: rtl/spi_ram_responder.sv
// ---------------------------------------------------------------------------
// spi_ram_responder
// SPI Mode-0 responder that behaves like a small byte-wide serial RAM.
// Understands READ (0x03) and WRITE (0x02) followed by an address byte, with
// the address auto-incrementing (and wrapping) across a burst.
//
// Ports:
//   clk, rst        system clock (>= 8x SCK), asynchronous active-high reset
//   spi_cs_n        chip select from master, active low
//   spi_sck         SPI clock, CPOL=0
//   spi_mosi        master data, MSB first
//   spi_miso        responder data, MSB first; 0 outside READ
//   busy            high while the synchronized chip select is low
//   cmd_err         one-clk pulse on an unknown opcode
//   dbg_addr        debug read address (low log2(DEPTH) bits used)
//   dbg_data        combinational memory contents at dbg_addr
// ---------------------------------------------------------------------------
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       busy,
    output logic       cmd_err,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int AW = $clog2(DEPTH);

    logic cs_n_s, mosi_s, sck_rise, sck_fall;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            miso_q, miso_d;
    logic            cmd_err_q, cmd_err_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [7:0]      mem_wdata;
    logic [7:0]      rx_byte;
    logic [AW-1:0]   rx_addr;
    logic            byte_done;
    logic            unused_bits;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    // rx_byte is the byte as it will look after this rise, so the FSM can act
    // on a completed byte in the same clk as its last bit arrives.
    assign rx_byte   = {rx_shift_q[6:0], mosi_s};
    assign rx_addr   = rx_byte[AW-1:0];
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

    // Next-state logic. Deselect has absolute priority: it wins over a
    // byte-completing rise in the same clk, so a torn transfer never writes.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        addr_d     = addr_q;
        miso_d     = 1'b0;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = rx_byte;

        if (cs_n_s) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            if (sck_rise) begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end

            unique case (state_q)
                IDLE: begin
                    state_d = CMD;
                end
                CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_READ) begin
                            state_d = RADDR;
                        end else if (rx_byte == CMD_WRITE) begin
                            state_d = WADDR;
                        end else begin
                            state_d   = IGNORE;
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                RADDR: begin
                    if (byte_done) begin
                        tx_shift_d = mem_q[rx_addr];
                        addr_d     = rx_addr + AW'(1);
                        state_d    = READ;
                    end
                end
                WADDR: begin
                    if (byte_done) begin
                        addr_d  = rx_addr;
                        state_d = WRITE;
                    end
                end
                READ: begin
                    // Shift out on the fall so the bit is stable well before
                    // the master samples on the following rise.
                    miso_d = miso_q;
                    if (sck_fall) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        tx_shift_d = mem_q[addr_q];
                        addr_d     = addr_q + AW'(1);
                    end
                end
                WRITE: begin
                    if (byte_done) begin
                        mem_we = 1'b1;
                        addr_d = addr_q + AW'(1);
                    end
                end
                IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Memory update: at most one byte written per clk.
    always_comb begin
        mem_d = mem_q;
        if (mem_we) begin
            mem_d[mem_waddr] = mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            addr_q     <= '0;
            miso_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            addr_q     <= addr_d;
            miso_q     <= miso_d;
            cmd_err_q  <= cmd_err_d;
            mem_q      <= mem_d;
        end
    end

    assign spi_miso = miso_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = ~cs_n_s;
    assign dbg_data = mem_q[dbg_addr[AW-1:0]];

    // Upper debug-address bits and the oldest receive bit are intentionally
    // ignored.
    assign unused_bits = ^{dbg_addr, rx_shift_q[7]};

endmodule

// File: tb/tb_spi_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_responder
// Drives the responder as an SPI Mode-0 master at f_clk = 8 x f_sck and
// compares what comes back against a byte-level RAM model.
// ---------------------------------------------------------------------------
module tb_spi_ram_responder;
    import spi_ram_pkg::*;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       busy;
    logic       cmd_err;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;

    int compared;
    int failed;
    int err_pulses;

    logic [7:0] tx_buf  [8];
    logic [7:0] rx_buf  [8];
    logic [7:0] exp_buf [8];
    int         exp_err;
    int         got_err;
    logic [7:0] model_mem [DEPTH];

    // Directed vectors: bytes sent (MSB-first packing), length, bytes
    // expected back on MISO, expected cmd_err pulses.
    typedef struct {
        logic [63:0] tx;
        int          len;
        logic [63:0] rx;
        int          err;
    } vec_t;

    vec_t vecs [8];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } dbg_vec_t;

    dbg_vec_t dbg_vecs [6];

    spi_ram_responder #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .busy     (busy),
        .cmd_err  (cmd_err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cmd_err pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmd_err) err_pulses++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Clock nbits bits of val, MSB first, sampling MISO just before each rise.
    task automatic spiBits(input logic [7:0] val, input int nbits, output logic [7:0] rxv);
        rxv = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sck  = 1'b0;
            spi_mosi = val[i];
            repeat (4) @(negedge clk);
            rxv[i]  = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    // One full transaction from tx_buf; results land in rx_buf/got_err.
    // Chip select stays high for two SCK periods afterwards.
    task automatic applyStimulus(input int len);
        int start;
        logic [7:0] r;
        start    = err_pulses;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy_during", {31'b0, busy}, 32'd1);
        for (int j = 0; j < len; j++) begin
            spiBits(tx_buf[j], 8, r);
            rx_buf[j] = r;
        end
        spi_sck = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (16) @(negedge clk);
        checkOutput("busy_after", {31'b0, busy}, 32'd0);
        got_err = err_pulses - start;
    endtask

    // Reference: a RAM addressed modulo DEPTH; reads return zero on the
    // opcode and address bytes, unknown opcodes touch nothing.
    task automatic modelTransaction(input int len);
        int a;
        for (int j = 0; j < 8; j++) exp_buf[j] = 8'h00;
        exp_err = 0;
        if (len >= 1) begin
            if (tx_buf[0] == CMD_READ) begin
                for (int j = 2; j < len; j++) begin
                    a = (int'(tx_buf[1]) + j - 2) % DEPTH;
                    exp_buf[j] = model_mem[a];
                end
            end else if (tx_buf[0] == CMD_WRITE) begin
                for (int j = 2; j < len; j++) begin
                    a = (int'(tx_buf[1]) + j - 2) % DEPTH;
                    model_mem[a] = tx_buf[j];
                end
            end else begin
                exp_err = 1;
            end
        end
    endtask

    task automatic runChecked(input int len, input string tag);
        modelTransaction(len);
        applyStimulus(len);
        for (int j = 0; j < len; j++) begin
            checkOutput($sformatf("%s_byte%0d", tag, j), {24'b0, rx_buf[j]}, {24'b0, exp_buf[j]});
        end
        checkOutput($sformatf("%s_cmd_err", tag), got_err, exp_err);
    endtask

    task automatic checkMem(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = 8'(a);
            #1;
            checkOutput($sformatf("%s_mem%0d", tag, a), {24'b0, dbg_data}, {24'b0, model_mem[a]});
        end
        @(negedge clk);
    endtask

    task automatic loadTx(input logic [63:0] packed_tx);
        for (int j = 0; j < 8; j++) tx_buf[j] = packed_tx[63 - 8*j -: 8];
    endtask

    initial begin
        logic [7:0] r;
        logic [63:0] exp_bytes;
        int len;
        int kind;

        compared   = 0;
        failed     = 0;
        err_pulses = 0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;

        vecs[0] = '{64'h02_05_A5_3C_00_00_00_00, 4, 64'h00_00_00_00_00_00_00_00, 0};
        vecs[1] = '{64'h03_05_00_00_00_00_00_00, 4, 64'h00_00_A5_3C_00_00_00_00, 0};
        vecs[2] = '{64'h02_0F_11_22_00_00_00_00, 4, 64'h00_00_00_00_00_00_00_00, 0};
        vecs[3] = '{64'h03_0F_00_00_00_00_00_00, 4, 64'h00_00_11_22_00_00_00_00, 0};
        vecs[4] = '{64'h9F_05_FF_FF_00_00_00_00, 4, 64'h00_00_00_00_00_00_00_00, 1};
        vecs[5] = '{64'h03_05_00_00_00_00_00_00, 5, 64'h00_00_A5_3C_00_00_00_00, 0};
        vecs[6] = '{64'h03_15_00_00_00_00_00_00, 3, 64'h00_00_A5_00_00_00_00_00, 0};
        vecs[7] = '{64'h03_0E_00_00_00_00_00_00, 5, 64'h00_00_00_11_22_00_00_00, 0};

        dbg_vecs[0] = '{8'h05, 8'hA5};
        dbg_vecs[1] = '{8'h06, 8'h3C};
        dbg_vecs[2] = '{8'h0F, 8'h11};
        dbg_vecs[3] = '{8'h00, 8'h22};
        dbg_vecs[4] = '{8'h25, 8'hA5};
        dbg_vecs[5] = '{8'h07, 8'h00};

        rst      = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        dbg_addr = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_miso", {31'b0, spi_miso}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_cmd_err", {31'b0, cmd_err}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkMem("reset");

        // Directed table: write/read, burst wrap, unknown opcode, truncation
        for (int i = 0; i < 8; i++) begin
            loadTx(vecs[i].tx);
            modelTransaction(vecs[i].len);
            applyStimulus(vecs[i].len);
            exp_bytes = vecs[i].rx;
            for (int j = 0; j < vecs[i].len; j++) begin
                checkOutput($sformatf("vec%0d_byte%0d", i, j), {24'b0, rx_buf[j]},
                            {24'b0, exp_bytes[63 - 8*j -: 8]});
            end
            checkOutput($sformatf("vec%0d_cmd_err", i), got_err, vecs[i].err);
        end

        for (int i = 0; i < 6; i++) begin
            dbg_addr = dbg_vecs[i].addr;
            #1;
            checkOutput($sformatf("dbg%0d", i), {24'b0, dbg_data}, {24'b0, dbg_vecs[i].data});
        end
        @(negedge clk);
        checkMem("after_table");

        // Abort mid-byte: prime mem[2], then tear a write after 5 data bits
        loadTx(64'h02_02_5A_00_00_00_00_00);
        runChecked(3, "prime");
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spiBits(CMD_WRITE, 8, r);
        spiBits(8'h02, 8, r);
        spiBits(8'hFF, 5, r);
        spi_sck = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (16) @(negedge clk);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        dbg_addr = 8'h02;
        #1;
        checkOutput("abort_mem2", {24'b0, dbg_data}, 32'h5A);
        @(negedge clk);
        loadTx(64'h03_02_00_00_00_00_00_00);
        runChecked(3, "abort_read");

        // Reset during the 4th data bit of a READ of mem[15] = 0x11
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spiBits(CMD_READ, 8, r);
        spiBits(8'h0F, 8, r);
        spiBits(8'h00, 3, r);
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_miso", {31'b0, spi_miso}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_miso", {31'b0, spi_miso}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
        checkMem("rst");
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        loadTx(64'h02_03_C3_00_00_00_00_00);
        runChecked(3, "post_rst_wr");
        loadTx(64'h03_03_00_00_00_00_00_00);
        runChecked(3, "post_rst_rd");

        // Randomized back-to-back traffic against the model
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                tx_buf[0] = CMD_READ;
            end else if (kind == 3) begin
                do tx_buf[0] = 8'($urandom); while (tx_buf[0] == CMD_READ || tx_buf[0] == CMD_WRITE);
            end else begin
                tx_buf[0] = CMD_WRITE;
            end
            for (int j = 1; j < 8; j++) tx_buf[j] = 8'($urandom);
            len = 2 + $urandom_range(0, 4);
            runChecked(len, $sformatf("rand%0d", t));
        end
        checkMem("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
